// File: rtl/uart_tx_dev.sv
// Bridge-attached UART transmitter: byte FIFO drained as 8N1 frames on txd, with a "drained" level IRQ.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_dev #(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned FIFO_AW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        txd,
  output logic        IRQ
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = 16;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wptr;
  logic [FIFO_AW-1:0]   r_rptr;
  logic [CW-1:0]        r_count;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_idx;
  logic [BW-1:0]        r_baud;
  logic                 r_busy;
  logic                 r_irq_en;
  logic                 r_ovf;
  logic                 r_txd;
  logic                 r_irq;

  logic w_empty;
  logic w_full;
  logic w_tx_wr;
  logic w_st_wr;
  logic w_push;
  logic w_ovf_set;
  logic w_baud_end;
  logic w_pop;
  logic w_bit_step;
  logic w_busy_clr;
  logic w_txd_nxt;
  logic w_unused;

  assign w_empty    = (r_count == CW'(0));
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_tx_wr    = we_i && (addr_i == 2'd0);
  assign w_st_wr    = we_i && (addr_i == 2'd1);
  assign w_push     = w_tx_wr && !w_full;
  assign w_ovf_set  = w_tx_wr && w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_unused   = &{1'b0, data_in[31:8], data_in[2:0]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_nxt = S_START;
      S_START:  if (w_baud_end) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_baud_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY: if (w_baud_end) w_state_nxt = S_STOP;
      S_STOP:   if (w_baud_end) w_state_nxt = w_empty ? S_IDLE : S_START;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop, bit stepping, busy release and next line level
  always_comb begin
    w_pop      = 1'b0;
    w_bit_step = 1'b0;
    w_busy_clr = 1'b0;
    w_txd_nxt  = 1'b1;
    case (r_state)
      S_IDLE:   w_pop = !w_empty;
      S_START:  w_txd_nxt = 1'b0;
      S_DATA: begin
        w_txd_nxt  = r_shift[r_bit_idx];
        w_bit_step = w_baud_end;
      end
      S_PARITY: w_txd_nxt = ^r_shift;
      S_STOP: begin
        w_pop      = w_baud_end && !w_empty;
        w_busy_clr = w_baud_end && w_empty;
      end
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Shifter, bit index and baud timing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
      r_busy    <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      if (w_pop) begin
        r_shift   <= r_mem[r_rptr];
        r_bit_idx <= '0;
      end else if (w_bit_step) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_state == S_IDLE) || w_baud_end) r_baud <= '0;
      else                                  r_baud <= r_baud + BW'(1);
      if (w_pop)           r_busy <= 1'b1;
      else if (w_busy_clr) r_busy <= 1'b0;
      r_txd <= w_txd_nxt;
    end
  end

  // Control/status bits and the drained interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_st_wr) r_irq_en <= data_in[3];
      if (w_ovf_set)                  r_ovf <= 1'b1;
      else if (w_st_wr && data_in[4]) r_ovf <= 1'b0;
      r_irq <= r_irq_en && w_empty && !r_busy;
    end
  end

  always_comb begin
    data_out = '0;
    case (addr_i)
      2'd1:    data_out = {26'b0, PAR_EN, r_ovf, r_irq_en, r_busy, w_full, w_empty};
      2'd2:    data_out = 32'(r_count);
      default: data_out = '0;
    endcase
  end

  assign txd = r_txd;
  assign IRQ = r_irq;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Testbench for uart_tx_dev: register table, directed frame/IRQ/overflow/reset sequences,
// and random traffic checked every cycle against a frame-level queue model.
module tb_uart_tx_dev;

  localparam int unsigned B     = 4;
  localparam int unsigned DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int unsigned NB    = 11;
  localparam logic [31:0] PARB  = 32'h20;
`else
  localparam int unsigned NB    = 10;
  localparam logic [31:0] PARB  = 32'h0;
`endif
  localparam int unsigned FRAME = NB * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        txd;
  logic        IRQ;

  uart_tx_dev #(.BAUD_DIV(B), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_in(data_in),
    .data_out(data_out), .txd(txd), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a frame timer counting cycles left in the current frame
  logic [7:0] q[$];
  int         rem = 0;
  int         pre_cnt;
  logic [7:0] cur = 8'd0;
  logic       m_ovf = 1'b0;
  logic       m_irq_en = 1'b0;
  logic       m_irq = 1'b0;
  logic       exp_txd = 1'b1;

  function automatic logic line_bit(input int r, input logic [7:0] c);
    int b;
    if (r == 0) return 1'b1;
    b = (int'(FRAME) - r) / int'(B);
    if (b == 0) return 1'b0;
    if (b <= 8) return c[b-1];
`ifdef UART_PARITY_EN
    if (b == 9) return ^c;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 2'd1) begin
      v    = PARB;
      v[4] = m_ovf;
      v[3] = m_irq_en;
      v[2] = (rem != 0);
      v[1] = (q.size() == DEPTH);
      v[0] = (q.size() == 0);
    end else if (a == 2'd2) begin
      v = 32'(q.size());
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      rem = 0;
      m_ovf = 1'b0;
      m_irq_en = 1'b0;
      m_irq = 1'b0;
      exp_txd = 1'b1;
    end else begin
      pre_cnt = q.size();
      exp_txd = line_bit(rem, cur);
      m_irq   = m_irq_en && (pre_cnt == 0) && (rem == 0);
      if (rem <= 1) begin
        if (pre_cnt > 0) begin
          cur = q.pop_front();
          rem = int'(FRAME);
        end else begin
          rem = 0;
        end
      end else begin
        rem = rem - 1;
      end
      if (we_i && addr_i == 2'd0) begin
        if (pre_cnt < int'(DEPTH)) q.push_back(data_in[7:0]);
        else m_ovf = 1'b1;
      end else if (we_i && addr_i == 2'd1) begin
        m_irq_en = data_in[3];
        if (data_in[4]) m_ovf = 1'b0;
      end
    end
  end

  // One clock: check outputs of the edge just taken, then drive inputs for the next edge
  task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    check("txd", 32'(txd), 32'(exp_txd));
    check("irq", 32'(IRQ), 32'(m_irq));
    check("rdata", data_out, model_read(addr_i));
    we_i = we;
    addr_i = a;
    data_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd1, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t       tbl[11];
  logic [NB-1:0] fr;
  int         r;

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 2'd1, 32'h0,        PARB | 32'h1};
    tbl[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 2'd1, 32'h8,        PARB | 32'h9};
    tbl[5]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{1'b1, 2'd1, 32'h10,       PARB | 32'h1};
    tbl[8]  = '{1'b1, 2'd1, 32'hFFFFFFF7, PARB | 32'h1};
    tbl[9]  = '{1'b1, 2'd1, 32'h8,        PARB | 32'h9};
    tbl[10] = '{1'b1, 2'd1, 32'h0,        PARB | 32'h1};

    step(1'b0, 2'd0, 32'd0);
    step(1'b0, 2'd0, 32'd0);
    rst = 1'b0;
    step(1'b0, 2'd1, 32'd0);
    #1;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq", 32'(IRQ), 32'd0);
    check("reset_status", data_out, PARB | 32'h1);

    // Register map table
    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      step(1'b0, tbl[i].addr, 32'd0);
      #1;
      check("tbl", data_out, tbl[i].exp);
    end
    idle(3);

    // Single 0xA5 frame: exact line waveform and busy release
`ifdef UART_PARITY_EN
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    fr = {1'b1, 8'hA5, 1'b0};
`endif
    step(1'b1, 2'd0, 32'hA5);
    for (int t = 0; t <= int'(FRAME) + 4; t++) begin
      step(1'b0, 2'd1, 32'd0);
      #1;
      if (t < 2 || t >= 2 + int'(FRAME)) check("a5_txd", 32'(txd), 32'd1);
      else check("a5_txd", 32'(txd), 32'(fr[(t-2)/int'(B)]));
      if (t == int'(FRAME))     check("a5_busy_hi", 32'(data_out[2]), 32'd1);
      if (t == int'(FRAME) + 1) check("a5_busy_lo", 32'(data_out[2]), 32'd0);
    end
    idle(3);

    // Back-to-back frames with no idle gap
    step(1'b1, 2'd0, 32'h11);
    step(1'b1, 2'd0, 32'h22);
    for (int t = 1; t <= 2 * int'(FRAME) + 4; t++) begin
      step(1'b0, 2'd2, 32'd0);
      #1;
      if (t == 1 || t == int'(FRAME)) check("b2b_count1", data_out, 32'd1);
      if (t == int'(FRAME) + 1)       check("b2b_count0", data_out, 32'd0);
      if (t == 1 || t == int'(FRAME) + 1 || t == 2 * int'(FRAME) + 2)
        check("b2b_txd_hi", 32'(txd), 32'd1);
      if (t == 2 || t == int'(FRAME) + 2) check("b2b_start", 32'(txd), 32'd0);
    end
    idle(3);

    // Fill: nine writes with one pop leave the FIFO exactly full; the tenth overflows
    for (int i = 1; i <= 9; i++) step(1'b1, 2'd0, 32'(i * 17));
    step(1'b0, 2'd1, 32'd0);
    #1;
    check("fill_status", data_out, PARB | 32'h6);
    step(1'b1, 2'd0, 32'h99);
    step(1'b0, 2'd2, 32'd0);
    #1;
    check("ovf_count", data_out, 32'd8);
    step(1'b0, 2'd1, 32'd0);
    #1;
    check("ovf_status", data_out, PARB | 32'h16);
    step(1'b1, 2'd1, 32'h10);
    step(1'b0, 2'd1, 32'd0);
    #1;
    check("ovf_clear", data_out, PARB | 32'h6);
    idle(9 * int'(FRAME) + 10);

    // Drained interrupt
    step(1'b1, 2'd1, 32'h8);
    step(1'b0, 2'd1, 32'd0);
    #1;
    check("irq_lag", 32'(IRQ), 32'd0);
    step(1'b0, 2'd1, 32'd0);
    #1;
    check("irq_set", 32'(IRQ), 32'd1);
    step(1'b1, 2'd0, 32'h3C);
    step(1'b0, 2'd1, 32'd0);
    #1;
    check("irq_hold", 32'(IRQ), 32'd1);
    for (int t = 1; t <= int'(FRAME) + 3; t++) begin
      step(1'b0, 2'd1, 32'd0);
      #1;
      if (t == 1)               check("irq_drop", 32'(IRQ), 32'd0);
      if (t == int'(FRAME) + 1) check("irq_busy_lo", 32'(data_out[2]), 32'd0);
      if (t == int'(FRAME) + 1) check("irq_still_lo", 32'(IRQ), 32'd0);
      if (t == int'(FRAME) + 2) check("irq_back", 32'(IRQ), 32'd1);
    end
    step(1'b1, 2'd1, 32'h0);
    idle(3);

    // Reset in the middle of the data bits with a second byte queued
    step(1'b1, 2'd0, 32'h5A);
    step(1'b1, 2'd0, 32'hC3);
    for (int t = 0; t < 2 + 4 * int'(B); t++) step(1'b0, 2'd2, 32'd0);
    rst = 1'b1;
    step(1'b0, 2'd2, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_count", data_out, 32'd0);
    addr_i = 2'd1;
    #1;
    check("rst_status", data_out, PARB | 32'h1);
    for (int t = 0; t < 2 * int'(FRAME); t++) begin
      step(1'b0, 2'd1, 32'd0);
      #1;
      check("rst_quiet", 32'(txd), 32'd1);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        rst = 1'b1;
        step(1'b0, 2'($urandom_range(0, 3)), 32'd0);
        rst = 1'b0;
      end else if (r < 90) step(1'b1, 2'd0, $urandom);
      else if (r < 120)    step(1'b1, 2'd1, $urandom);
      else if (r < 130)    step(1'b1, 2'($urandom_range(2, 3)), $urandom);
      else                 step(1'b0, 2'($urandom_range(0, 3)), 32'd0);
    end
    idle(9 * int'(FRAME) + 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
